pport_seq: RTL
==============

Name: pport_seq

Overview:
- Parametrised successor to the single-cycle peripheral-port glue: a sequenced controller for the 8/16-bit peripheral bus (WD33C93A plus spare ports).
- Runs CPU PIO cycles and DREQ/DACK DMA cycles with programmable setup/strobe/hold timing and _IORDY wait states.
- Owns the word transfer counter (WTC) and raises terminal-count and timeout status.
- Sits between the register decoder / bus-master logic and the PD_PORT pins; one SCLK domain.

Parameters:
DW, 16, peripheral data width (8 or 16)
NCS, 3, number of peripheral chip selects
CNT_W, 24, WTC width
T_SU, 1, setup cycles (CS/DACK asserted, strobe negated), >=1
T_STB, 3, minimum strobe-low cycles, >=1
T_HLD, 1, hold cycles after strobe negation, >=1
WAIT_MAX, 255, max _IORDY wait cycles before timeout

Ports:
SCLK  in  1  clock (CPUCLKB)
_RST  in  1  reset
PIO_REQ  in  1  CPU port access request, held until PIO_ACK
PIO_RW  in  1  1=read peripheral
PIO_SEL  in  NCS  one-hot chip select
PIO_WDATA  in  DW  write data
PIO_RDATA  out  DW  read data, valid with PIO_ACK
PIO_ACK  out  1  one-cycle completion pulse
DMA_EN  in  1  DMA enable from control register
DMA_DIR  in  1  1=peripheral->memory
WTC_LOAD  in  1  load WTC from WTC_IN
WTC_IN  in  CNT_W  count value
WTC  out  CNT_W  current count
DMA_WDATA  in  DW  memory->peripheral word
DMA_WVALID  in  1  DMA_WDATA valid
DMA_WREADY  out  1  word consumed (one-cycle pulse)
DMA_RDATA  out  DW  peripheral->memory word
DMA_RVALID  out  1  DMA_RDATA held valid
DMA_RREADY  in  1  memory side took DMA_RDATA
TC  out  1  sticky terminal count
ERR  out  1  sticky _IORDY timeout
STAT_CLR  in  1  clears TC and ERR
_DREQ  in  1  peripheral DMA request, active low
_DACK  out  1  DMA acknowledge, active low
_IORDY  in  1  peripheral ready, low = wait
_CSN  out  NCS  chip selects, active low
_IOR  out  1  read strobe, active low
_IOW  out  1  write strobe, active low
P_DOUT  out  DW  data to peripheral
P_OE  out  1  drive P_DOUT onto port
P_DIN  in  DW  data from peripheral

Behaviour:
- Reset (_RST low, async, any state): FSM IDLE; _CSN all 1, _DACK/_IOR/_IOW 1, P_OE 0, P_DOUT 0.
- Reset values, continued: PIO_ACK/DMA_WREADY/DMA_RVALID 0, WTC 0, TC/ERR 0, PIO_RDATA/DMA_RDATA 0. No partial cycle completes.
- FSM states: IDLE -> SETUP(T_SU) -> STROBE(T_STB) -> [WAIT] -> HOLD(T_HLD) -> IDLE.
- IDLE arbitration: PIO_REQ wins over DMA.
- DMA is eligible when DMA_EN=1, _DREQ=0, WTC!=0, and either DMA_DIR=1 with DMA_RVALID=0, or DMA_DIR=0 with DMA_WVALID=1.
- Inputs latched at IDLE exit: command, selects, write data.
- PIO_SEL==0: no bus cycle; PIO_ACK next cycle with PIO_RDATA=0.
- PIO cycle drives _CSN=~PIO_SEL from SETUP through HOLD; _DACK stays 1.
- DMA cycle drives _DACK=0 from SETUP through HOLD; _CSN stays all 1.
- Write cycles: P_OE=1 and P_DOUT stable from SETUP through HOLD. _IOW low in STROBE/WAIT.
- Read cycles: P_OE=0, _IOR low in STROBE/WAIT.
- End of STROBE: if _IORDY=1, go to HOLD; else enter WAIT.
- WAIT exits to HOLD on the first cycle with _IORDY=1.
- Timeout: after WAIT_MAX WAIT cycles, go to HOLD, set ERR, read data = all ones.
- Read data is sampled from P_DIN on the clock edge leaving STROBE/WAIT.
- Last HOLD cycle: PIO cycles pulse PIO_ACK. DMA reads set DMA_RVALID (cleared on DMA_RREADY). DMA writes pulse DMA_WREADY. WTC decrements.
- WTC decrement 1->0 sets TC; DMA stops at WTC=0 and never wraps.
- WTC_LOAD has priority over a same-cycle decrement. STAT_CLR coincident with a TC/ERR set: the set wins.
- DMA_EN or _DREQ negated mid-cycle: the current cycle completes; no new DMA cycle starts.
- PIO_REQ dropped before ACK: the cycle still completes and ACK is still pulsed.
- DW=8: upper bits absent; all datapaths are DW wide.

Test Plan:
- PIO write, defaults: PIO_SEL=3'b001, data 16'hA55A -> _CSN[0] low 5 cycles, _IOW low 3 cycles starting cycle 2, P_DOUT=A55A throughout, PIO_ACK at cycle 5.
- PIO read with _IORDY low for 4 cycles during STROBE -> _IOR low 7 cycles, PIO_RDATA = P_DIN value at release, ERR=0.
- DMA read, WTC_LOAD=3, _DREQ held low, DMA_RREADY pulsed after each RVALID -> exactly 3 _DACK cycles, WTC 3->2->1->0, TC=1, no 4th cycle.
- PIO_REQ and DMA both pending in IDLE -> PIO cycle first, DMA next; a WTC_LOAD=5 coincident with a decrement leaves WTC=5.
- _IORDY stuck low, WAIT_MAX=255 -> exit after 255 WAIT cycles, ERR=1, read data FFFF; STAT_CLR clears ERR.
- _RST asserted mid-STROBE of a DMA write -> _IOW/_DACK high immediately, WTC=0, no DMA_WREADY pulse.

Source files
------------

// File: rtl/pport_seq.sv
//------------------------------------------------------------------------------
// pport_seq
//   Sequenced controller for the 8/16-bit peripheral port (WD33C93A plus spare
//   ports). It runs CPU PIO cycles and DREQ/DACK DMA cycles with programmable
//   setup/strobe/hold timing and _IORDY wait states. It owns the word transfer
//   counter (WTC) and flags terminal count and _IORDY timeout. Single SCLK
//   domain.
//
// Ports
//   SCLK, _RST                 clock, async active-low reset
//   PIO_REQ/RW/SEL/WDATA       CPU request side; PIO_RDATA/PIO_ACK completion
//   DMA_EN/DMA_DIR             DMA control (DIR=1: peripheral->memory)
//   WTC_LOAD/WTC_IN/WTC        word transfer counter load and readback
//   DMA_WDATA/WVALID/WREADY    memory->peripheral word handshake
//   DMA_RDATA/RVALID/RREADY    peripheral->memory word handshake
//   TC, ERR, STAT_CLR          sticky status and its clear
//   _DREQ/_DACK/_IORDY/_CSN    peripheral handshake and selects (active low)
//   _IOR/_IOW                  peripheral strobes (active low)
//   P_DOUT/P_OE/P_DIN          peripheral data path
//------------------------------------------------------------------------------
module pport_seq #(
   parameter int DW       = 16,
   parameter int NCS      = 3,
   parameter int CNT_W    = 24,
   parameter int T_SU     = 1,
   parameter int T_STB    = 3,
   parameter int T_HLD    = 1,
   parameter int WAIT_MAX = 255
) (
   input  logic             SCLK,
   input  logic             _RST,
   input  logic             PIO_REQ,
   input  logic             PIO_RW,
   input  logic [NCS-1:0]   PIO_SEL,
   input  logic [DW-1:0]    PIO_WDATA,
   output logic [DW-1:0]    PIO_RDATA,
   output logic             PIO_ACK,
   input  logic             DMA_EN,
   input  logic             DMA_DIR,
   input  logic             WTC_LOAD,
   input  logic [CNT_W-1:0] WTC_IN,
   output logic [CNT_W-1:0] WTC,
   input  logic [DW-1:0]    DMA_WDATA,
   input  logic             DMA_WVALID,
   output logic             DMA_WREADY,
   output logic [DW-1:0]    DMA_RDATA,
   output logic             DMA_RVALID,
   input  logic             DMA_RREADY,
   output logic             TC,
   output logic             ERR,
   input  logic             STAT_CLR,
   input  logic             _DREQ,
   output logic             _DACK,
   input  logic             _IORDY,
   output logic [NCS-1:0]   _CSN,
   output logic             _IOR,
   output logic             _IOW,
   output logic [DW-1:0]    P_DOUT,
   output logic             P_OE,
   input  logic [DW-1:0]    P_DIN
);

   localparam int C_M1  = (T_SU > T_STB) ? T_SU : T_STB;
   localparam int C_M2  = (C_M1 > T_HLD) ? C_M1 : T_HLD;
   localparam int C_MAX = (C_M2 > WAIT_MAX) ? C_M2 : WAIT_MAX;
   localparam int CW    = $clog2(C_MAX + 1);

   localparam logic [CW-1:0] C_SU_LAST   = CW'(T_SU - 1);
   localparam logic [CW-1:0] C_STB_LAST  = CW'(T_STB - 1);
   localparam logic [CW-1:0] C_HLD_LAST  = CW'(T_HLD - 1);
   localparam logic [CW-1:0] C_WAIT_LAST = CW'(WAIT_MAX - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_HOLD
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_dma, w_dma_nxt;
   logic             r_rd, w_rd_nxt;
   logic [NCS-1:0]   r_sel, w_sel_nxt;
   logic [DW-1:0]    r_wdata, w_wdata_nxt;

   logic             r_pio_ack, r_wready, r_rvalid, r_tc, r_err;
   logic             r_dackn, r_iorn, r_iown, r_oe;
   logic [NCS-1:0]   r_csn;
   logic [DW-1:0]    r_pio_rdata, r_dma_rdata;
   logic [CNT_W-1:0] r_wtc;

   logic w_pio_take, w_dma_elig, w_nobus, w_release, w_timeout, w_done;
   logic w_active_nxt, w_strobe_nxt, w_last_hold_nxt, w_dec;

   // A no-bus PIO acks from IDLE while REQ is still held; masking REQ during
   // that ack keeps the same request from being taken twice.
   assign w_pio_take = PIO_REQ && !r_pio_ack;
   assign w_dma_elig = DMA_EN && !_DREQ && (r_wtc != '0) &&
                       (DMA_DIR ? !r_rvalid : DMA_WVALID);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dma_nxt   = r_dma;
      w_rd_nxt    = r_rd;
      w_sel_nxt   = r_sel;
      w_wdata_nxt = r_wdata;
      w_nobus     = 1'b0;
      w_release   = 1'b0;
      w_timeout   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pio_take) begin
               if (PIO_SEL == '0) begin
                  w_nobus = 1'b1;
               end else begin
                  w_state_nxt = S_SETUP;
                  w_cnt_nxt   = '0;
                  w_dma_nxt   = 1'b0;
                  w_rd_nxt    = PIO_RW;
                  w_sel_nxt   = PIO_SEL;
                  if (!PIO_RW) w_wdata_nxt = PIO_WDATA;
               end
            end else if (w_dma_elig) begin
               w_state_nxt = S_SETUP;
               w_cnt_nxt   = '0;
               w_dma_nxt   = 1'b1;
               w_rd_nxt    = DMA_DIR;
               w_sel_nxt   = '0;
               if (!DMA_DIR) w_wdata_nxt = DMA_WDATA;
            end
         end
         S_SETUP: begin
            if (r_cnt == C_SU_LAST) begin
               w_state_nxt = S_STROBE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_STROBE: begin
            if (r_cnt == C_STB_LAST) begin
               w_cnt_nxt = '0;
               if (_IORDY) begin
                  w_state_nxt = S_HOLD;
                  w_release   = 1'b1;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_WAIT: begin
            if (_IORDY) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
               w_release   = 1'b1;
            end else if (r_cnt == C_WAIT_LAST) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
               w_timeout   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_HOLD: begin
            if (r_cnt == C_HLD_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_done      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Pins and pulses are registered from the next-state view so they line up
   // with the state they belong to and never glitch.
   assign w_active_nxt    = (w_state_nxt != S_IDLE);
   assign w_strobe_nxt    = (w_state_nxt == S_STROBE) || (w_state_nxt == S_WAIT);
   assign w_last_hold_nxt = (w_state_nxt == S_HOLD) && (w_cnt_nxt == C_HLD_LAST);
   assign w_dec           = w_done && r_dma && (r_wtc != '0);

   always_ff @(posedge SCLK or negedge _RST) begin
      if (!_RST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dma   <= 1'b0;
         r_rd    <= 1'b0;
         r_sel   <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dma   <= w_dma_nxt;
         r_rd    <= w_rd_nxt;
         r_sel   <= w_sel_nxt;
         r_wdata <= w_wdata_nxt;
      end
   end

   always_ff @(posedge SCLK or negedge _RST) begin
      if (!_RST) begin
         r_csn     <= '1;
         r_dackn   <= 1'b1;
         r_iorn    <= 1'b1;
         r_iown    <= 1'b1;
         r_oe      <= 1'b0;
         r_pio_ack <= 1'b0;
         r_wready  <= 1'b0;
      end else begin
         r_csn     <= (w_active_nxt && !w_dma_nxt) ? ~w_sel_nxt : '1;
         r_dackn   <= !(w_active_nxt && w_dma_nxt);
         r_iorn    <= !(w_strobe_nxt && w_rd_nxt);
         r_iown    <= !(w_strobe_nxt && !w_rd_nxt);
         r_oe      <= w_active_nxt && !w_rd_nxt;
         r_pio_ack <= w_nobus || (w_last_hold_nxt && !w_dma_nxt);
         r_wready  <= w_last_hold_nxt && w_dma_nxt && !w_rd_nxt;
      end
   end

   always_ff @(posedge SCLK or negedge _RST) begin
      if (!_RST) begin
         r_pio_rdata <= '0;
         r_dma_rdata <= '0;
         r_rvalid    <= 1'b0;
      end else begin
         if (w_nobus)
            r_pio_rdata <= '0;
         else if ((w_release || w_timeout) && r_rd && !r_dma)
            r_pio_rdata <= w_timeout ? '1 : P_DIN;
         if ((w_release || w_timeout) && r_rd && r_dma)
            r_dma_rdata <= w_timeout ? '1 : P_DIN;
         if (w_done && r_dma && r_rd)
            r_rvalid <= 1'b1;
         else if (DMA_RREADY)
            r_rvalid <= 1'b0;
      end
   end

   always_ff @(posedge SCLK or negedge _RST) begin
      if (!_RST) begin
         r_wtc <= '0;
         r_tc  <= 1'b0;
         r_err <= 1'b0;
      end else begin
         if (WTC_LOAD)
            r_wtc <= WTC_IN;
         else if (w_dec)
            r_wtc <= r_wtc - CNT_W'(1);
         // TC only when the 1->0 decrement really happens (a load overrides it)
         if (w_dec && !WTC_LOAD && (r_wtc == CNT_W'(1)))
            r_tc <= 1'b1;
         else if (STAT_CLR)
            r_tc <= 1'b0;
         if (w_timeout)
            r_err <= 1'b1;
         else if (STAT_CLR)
            r_err <= 1'b0;
      end
   end

   assign PIO_RDATA  = r_pio_rdata;
   assign PIO_ACK    = r_pio_ack;
   assign WTC        = r_wtc;
   assign DMA_WREADY = r_wready;
   assign DMA_RDATA  = r_dma_rdata;
   assign DMA_RVALID = r_rvalid;
   assign TC         = r_tc;
   assign ERR        = r_err;
   assign _DACK      = r_dackn;
   assign _CSN       = r_csn;
   assign _IOR       = r_iorn;
   assign _IOW       = r_iown;
   assign P_DOUT     = r_wdata;
   assign P_OE       = r_oe;

endmodule
